// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light conflict monitor: lamp codes,
// phase ids, the legal phase pattern table, fault codes and monitor states.
package traffic_light_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef logic [2:0] phase_id_t;

    localparam phase_id_t P1 = 3'd0;
    localparam phase_id_t P2 = 3'd1;
    localparam phase_id_t P3 = 3'd2;
    localparam phase_id_t P4 = 3'd3;
    localparam phase_id_t P5 = 3'd4;
    localparam phase_id_t P6 = 3'd5;

    localparam int NUM_PHASES = 6;

    typedef logic [2:0] fault_code_t;

    localparam fault_code_t FC_NONE     = 3'd0;
    localparam fault_code_t FC_ENC      = 3'd1;
    localparam fault_code_t FC_CONFLICT = 3'd2;
    localparam fault_code_t FC_SEQ      = 3'd3;
    localparam fault_code_t FC_SHORT    = 3'd4;
    localparam fault_code_t FC_LONG     = 3'd5;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    // Lamp set for one phase, ordered M1, M2, MT, S.
    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
    } lamp_set_t;

    // Legal phase pattern table.
    function automatic lamp_set_t phase_pattern(input phase_id_t id);
        lamp_set_t pat;
        case (id)
            P1:      pat = '{m1: GREEN,  m2: GREEN,  mt: RED,    s: RED};
            P2:      pat = '{m1: GREEN,  m2: YELLOW, mt: RED,    s: RED};
            P3:      pat = '{m1: GREEN,  m2: RED,    mt: GREEN,  s: RED};
            P4:      pat = '{m1: YELLOW, m2: RED,    mt: YELLOW, s: RED};
            P5:      pat = '{m1: RED,    m2: RED,    mt: RED,    s: GREEN};
            default: pat = '{m1: RED,    m2: RED,    mt: RED,    s: YELLOW};
        endcase
        return pat;
    endfunction

    // Successor phase in the fixed P1..P6 ring.
    function automatic phase_id_t next_phase(input phase_id_t id);
        return (id == P6) ? P1 : phase_id_t'(id + 3'd1);
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light bus as seen by the monitor plus the monitor's status outputs.
// master = controller/observer side, slave = monitor side.
interface traffic_light_monitor_if;
    import traffic_light_pkg::*;

    logic [2:0]  light_M1;
    logic [2:0]  light_S;
    logic [2:0]  light_MT;
    logic [2:0]  light_M2;
    logic        fault_clr;
    phase_id_t   phase;
    logic        phase_valid;
    logic        cycle_done;
    logic        fault;
    fault_code_t fault_code;

    modport master (
        output light_M1, light_S, light_MT, light_M2, fault_clr,
        input  phase, phase_valid, cycle_done, fault, fault_code
    );

    modport slave (
        input  light_M1, light_S, light_MT, light_M2, fault_clr,
        output phase, phase_valid, cycle_done, fault, fault_code
    );

endinterface

// File: rtl/traffic_light_phase_decode.sv
// Combinational decode of the four lamp buses into an encoding-ok flag,
// a legal-pattern match flag and the matching phase id.
module traffic_light_phase_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    output logic       enc_ok,
    output logic       phase_match,
    output phase_id_t  phase_id
);

    lamp_set_t lamps;

    // Check one-hot encoding and search the legal pattern table.
    always_comb begin
        lamps       = '{m1: light_M1, m2: light_M2, mt: light_MT, s: light_S};
        enc_ok      = $onehot(light_M1) && $onehot(light_M2) &&
                      $onehot(light_MT) && $onehot(light_S);
        phase_match = 1'b0;
        phase_id    = P1;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (lamps == phase_pattern(phase_id_t'(i))) begin
                phase_match = 1'b1;
                phase_id    = phase_id_t'(i);
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive conflict/malfunction monitor for the intersection light bus.
// Locks onto the running phase, checks encoding, conflicts, phase order and
// per-phase dwell, and latches the first fault until cleared.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int T_P1  = 7,
    parameter int T_P2  = 2,
    parameter int T_P3  = 5,
    parameter int T_P4  = 2,
    parameter int T_P5  = 3,
    parameter int T_P6  = 2,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_light_monitor_if.slave bus
);

    logic        enc_ok;
    logic        phase_match;
    phase_id_t   phase_id;

    mon_state_t  state_q, state_d;
    phase_id_t   cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        partial_q, partial_d;
    logic        phase_valid_q, phase_valid_d;
    logic        cycle_done_q, cycle_done_d;
    logic        fault_q, fault_d;
    fault_code_t fault_code_q, fault_code_d;

    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   dwell;
    logic [CNT_W-1:0] cnt_sat;
    fault_code_t      viol;

    // Expected dwell of a phase in cycles (terminal count + 1).
    function automatic logic [CNT_W:0] dwell_of(input phase_id_t p);
        case (p)
            P1:      return (CNT_W+1)'(T_P1 + 1);
            P2:      return (CNT_W+1)'(T_P2 + 1);
            P3:      return (CNT_W+1)'(T_P3 + 1);
            P4:      return (CNT_W+1)'(T_P4 + 1);
            P5:      return (CNT_W+1)'(T_P5 + 1);
            default: return (CNT_W+1)'(T_P6 + 1);
        endcase
    endfunction

    traffic_light_phase_decode u_decode (
        .light_M1    (bus.light_M1),
        .light_M2    (bus.light_M2),
        .light_MT    (bus.light_MT),
        .light_S     (bus.light_S),
        .enc_ok      (enc_ok),
        .phase_match (phase_match),
        .phase_id    (phase_id)
    );

    // Dwell arithmetic: one extra bit so the overflow and LONG test are exact.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + 1'b1;
        dwell   = dwell_of(cur_q);
        cnt_sat = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
    end

    // Next-state and output logic; the highest-priority violation wins.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        cnt_d        = cnt_q;
        partial_d    = partial_q;
        cycle_done_d = 1'b0;
        fault_code_d = fault_code_q;
        viol         = FC_NONE;

        unique case (state_q)
            ST_SYNC: begin
                if (!enc_ok) begin
                    viol = FC_ENC;
                end else if (!phase_match) begin
                    viol = FC_CONFLICT;
                end else begin
                    // Entry may be mid-phase, so this first phase is partial.
                    cur_d     = phase_id;
                    cnt_d     = CNT_W'(1);
                    partial_d = 1'b1;
                    state_d   = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!enc_ok) begin
                    viol = FC_ENC;
                end else if (!phase_match) begin
                    viol = FC_CONFLICT;
                end else if (phase_id == cur_q) begin
                    cnt_d = cnt_sat;
                    if (cnt_inc > dwell) begin
                        viol = FC_LONG;
                    end
                end else if (phase_id == next_phase(cur_q)) begin
                    if (!partial_q && ({1'b0, cnt_q} < dwell)) begin
                        viol = FC_SHORT;
                    end else begin
                        cur_d        = phase_id;
                        cnt_d        = CNT_W'(1);
                        partial_d    = 1'b0;
                        cycle_done_d = (phase_id == P1);
                    end
                end else begin
                    viol = FC_SEQ;
                end
            end
            ST_FAULT: begin
                // Latched: later violations are ignored until cleared.
                if (bus.fault_clr) begin
                    state_d      = ST_SYNC;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        if (viol != FC_NONE) begin
            state_d      = ST_FAULT;
            fault_code_d = viol;
        end

        phase_valid_d = (state_d == ST_TRACK);
        fault_d       = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            cur_q         <= P1;
            cnt_q         <= '0;
            partial_q     <= 1'b0;
            phase_valid_q <= 1'b0;
            cycle_done_q  <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            cnt_q         <= cnt_d;
            partial_q     <= partial_d;
            phase_valid_q <= phase_valid_d;
            cycle_done_q  <= cycle_done_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    assign bus.phase       = cur_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.cycle_done  = cycle_done_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed scenarios followed by a
// randomized controller with injected errors, every cycle compared against
// a behavioural model of the monitoring rules.
module tb_traffic_light_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    traffic_light_monitor_if bus();

    traffic_light_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int pulse_q[$];

    // Lamp codes: R=4, Y=2, G=1. Columns per phase P1..P6.
    int pat_m1 [6] = '{1, 1, 1, 2, 4, 4};
    int pat_m2 [6] = '{1, 2, 4, 4, 4, 4};
    int pat_mt [6] = '{4, 4, 1, 2, 4, 4};
    int pat_s  [6] = '{4, 4, 4, 4, 1, 2};
    int dw     [6] = '{8, 3, 6, 3, 4, 3};

    // Model state
    localparam int M_SYNC = 0, M_TRACK = 1, M_FAULT = 2;
    int m_mode, m_phase, m_cnt, m_code;
    bit m_partial, m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc_no, obs, exp);
        end
    endtask

    // -2 bad encoding, -1 one-hot but no legal phase, else phase index.
    function automatic int classify(input logic [2:0] a, input logic [2:0] b,
                                    input logic [2:0] c, input logic [2:0] d);
        if ($countones(a) != 1 || $countones(b) != 1 ||
            $countones(c) != 1 || $countones(d) != 1) return -2;
        for (int i = 0; i < 6; i++)
            if (int'(a) == pat_m1[i] && int'(b) == pat_m2[i] &&
                int'(c) == pat_mt[i] && int'(d) == pat_s[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_SYNC; m_phase = 0; m_cnt = 0; m_code = 0;
        m_partial = 0; m_done = 0;
    endtask

    task automatic model_step();
        int c;
        c = classify(bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S);
        m_done = 0;
        if (rst) begin
            model_reset();
        end else if (m_mode == M_FAULT) begin
            if (bus.fault_clr) begin m_mode = M_SYNC; m_code = 0; end
        end else if (c == -2) begin
            m_mode = M_FAULT; m_code = 1;
        end else if (c == -1) begin
            m_mode = M_FAULT; m_code = 2;
        end else if (m_mode == M_SYNC) begin
            m_phase = c; m_cnt = 1; m_partial = 1; m_mode = M_TRACK;
        end else if (c == m_phase) begin
            m_cnt++;
            if (m_cnt > dw[m_phase]) begin m_mode = M_FAULT; m_code = 5; end
        end else if (c == (m_phase + 1) % 6) begin
            if (!m_partial && m_cnt < dw[m_phase]) begin
                m_mode = M_FAULT; m_code = 4;
            end else begin
                m_phase = c; m_cnt = 1; m_partial = 0; m_done = (c == 0);
            end
        end else begin
            m_mode = M_FAULT; m_code = 3;
        end
    endtask

    // One clock: model samples with the DUT, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cyc_no++;
        if (bus.cycle_done === 1'b1) pulse_q.push_back(cyc_no);
        chk("phase",       bus.phase,       m_phase);
        chk("phase_valid", bus.phase_valid, m_mode == M_TRACK);
        chk("cycle_done",  bus.cycle_done,  m_done);
        chk("fault",       bus.fault,       m_mode == M_FAULT);
        chk("fault_code",  bus.fault_code,  m_code);
    endtask

    task automatic set_raw(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
        bus.light_M1 = a; bus.light_M2 = b; bus.light_MT = c; bus.light_S = d;
    endtask

    task automatic hold(input int ph, input int n);
        set_raw(3'(pat_m1[ph]), 3'(pat_m2[ph]), 3'(pat_mt[ph]), 3'(pat_s[ph]));
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    int gph;
    int n;
    int r;

    initial begin
        model_reset();
        rst = 1'b1;
        bus.fault_clr = 1'b0;
        set_raw(3'b100, 3'b100, 3'b100, 3'b010);
        cyc();
        hold(0, 1);
        chk("reset_valid", bus.phase_valid, 0);
        chk("reset_fault", bus.fault, 0);
        chk("reset_code",  bus.fault_code, 0);

        // Five nominal cycles after reset release.
        rst = 1'b0;
        pulse_q.delete();
        hold(0, 1);
        chk("t1_first_valid", bus.phase_valid, 1);
        chk("t1_first_phase", bus.phase, 0);
        hold(0, 7);
        for (int k = 0; k < 5; k++) begin
            for (int p = 1; p < 6; p++) hold(p, dw[p]);
            hold(0, (k == 4) ? 1 : 8);
        end
        chk("t1_pulses", pulse_q.size(), 5);
        for (int k = 1; k < pulse_q.size(); k++)
            chk("t1_gap", pulse_q[k] - pulse_q[k-1], 27);
        chk("t1_fault", bus.fault, 0);

        // Bad encoding during P3, latched until cleared.
        hold(0, 7); hold(1, 3); hold(2, 2);
        set_raw(3'b001, 3'b100, 3'b001, 3'b011);
        cyc();
        chk("t2_fault", bus.fault, 1);
        chk("t2_code", bus.fault_code, 1);
        chk("t2_valid", bus.phase_valid, 0);
        hold(2, 3);
        chk("t2_hold_code", bus.fault_code, 1);

        // Clear with P4 lights, resync onto a partial P4 then accept P5.
        bus.fault_clr = 1'b1;
        hold(3, 1);
        bus.fault_clr = 1'b0;
        chk("t6_clr_fault", bus.fault, 0);
        chk("t6_clr_valid", bus.phase_valid, 0);
        hold(3, 1);
        chk("t6_sync_phase", bus.phase, 3);
        chk("t6_sync_valid", bus.phase_valid, 1);
        hold(4, 1);
        chk("t6_p5_phase", bus.phase, 4);
        chk("t6_p5_fault", bus.fault, 0);

        // Conflict pattern.
        do_reset();
        hold(0, 3);
        set_raw(3'b001, 3'b001, 3'b100, 3'b001);
        cyc();
        chk("t3_code", bus.fault_code, 2);

        // Skipped phase.
        do_reset();
        hold(0, 8); hold(2, 1);
        chk("t4_code", bus.fault_code, 3);

        // Short P2.
        do_reset();
        hold(0, 8); hold(1, 2); hold(2, 1);
        chk("t5_short_code", bus.fault_code, 4);

        // Long P3.
        do_reset();
        hold(0, 8); hold(1, 3); hold(2, 6);
        chk("t5_no_long_yet", bus.fault, 0);
        hold(2, 1);
        chk("t5_long_code", bus.fault_code, 5);

        // Reset mid-P3.
        do_reset();
        hold(0, 8); hold(1, 3); hold(2, 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_phase", bus.phase, 0);
        chk("t6_rst_valid", bus.phase_valid, 0);
        chk("t6_rst_done", bus.cycle_done, 0);
        chk("t6_rst_fault", bus.fault, 0);

        // Randomized controller with occasional errors, clears and resets.
        gph = 0;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                gph = (gph + 1) % 6;
                n = dw[gph];
                case ($urandom_range(0, 7))
                    0: n = n - 1;
                    1: n = n + 1;
                    default: ;
                endcase
                if (n < 1) n = 1;
                hold(gph, n);
            end else if (r < 78) begin
                set_raw(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                        3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                cyc();
            end else if (r < 84) begin
                gph = $urandom_range(0, 5);
                hold(gph, $urandom_range(1, 3));
            end else if (r < 94) begin
                bus.fault_clr = 1'b1;
                cyc();
                bus.fault_clr = 1'b0;
            end else begin
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Conflict/malfunction monitor on the receiving end of the four-approach light bus driven by the intersection controller (light_M1, light_S, light_MT, light_M2). It decodes the bus into a phase number, checks encoding, conflicts, phase order and per-phase dwell time, and latches the first fault for the safety/flash logic. It observes only and never drives the lights.

Parameters:
T_P1, 7, P1 terminal count; expected dwell = T_P1+1 cycles
T_P2, 2, P2 terminal count; dwell = T_P2+1
T_P3, 5, P3 terminal count; dwell = T_P3+1
T_P4, 2, P4 terminal count; dwell = T_P4+1
T_P5, 3, P5 terminal count; dwell = T_P5+1
T_P6, 2, P6 terminal count; dwell = T_P6+1
CNT_W, 4, dwell counter width; must hold max(T_Px)+2

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
light_M1  in  3  main-1 lamp, one-hot {red,yellow,green} = 100/010/001
light_S  in  3  side-road lamp, same encoding
light_MT  in  3  main-turn lamp, same encoding
light_M2  in  3  main-2 lamp, same encoding
fault_clr  in  1  clears latched fault
phase  out  3  current phase id 0..5 (P1..P6)
phase_valid  out  1  monitor locked and tracking
cycle_done  out  1  one-cycle pulse on each accepted P6->P1 entry
fault  out  1  sticky fault flag
fault_code  out  3  0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 SHORT, 5 LONG

Behaviour:
- Legal phases (M1,M2,MT,S): P1 G,G,R,R; P2 G,Y,R,R; P3 G,R,G,R; P4 Y,R,Y,R; P5 R,R,R,G; P6 R,R,R,Y. Successor: P1->P2->...->P6->P1.
- Decode is combinational from inputs; all outputs are registered; 1-cycle latency from lights to outputs.
- Reset (any cycle, including mid-phase or in FAULT): state SYNC, phase=0, phase_valid=0, cycle_done=0, fault=0, fault_code=0, counter=0, partial=0.
- Checks per sampled cycle, priority ENC > CONFLICT > SEQ > SHORT > LONG; only the highest is reported.
  ENC: any lamp not exactly one-hot.
  CONFLICT: all lamps one-hot, but the pattern matches no legal phase.
- SYNC: ENC/CONFLICT -> FAULT. A legal phase p sets cur=p, cnt=1, partial=1 and goes to TRACK. No SEQ or SHORT check is made in SYNC.
- TRACK, sample p:
  p==cur: cnt+1; if cnt+1 > dwell(cur) -> FAULT LONG.
  p==next(cur): if partial==0 and cnt < dwell(cur) -> FAULT SHORT; else cur=p, cnt=1, partial=0. Pulse cycle_done if p==P1.
  other legal p -> FAULT SEQ.
  phase_valid=1 throughout TRACK.
- LONG is checked for the partial first phase; SHORT is not.
- FAULT: fault=1 and fault_code hold until fault_clr or rst. phase_valid=0. phase holds the last tracked value. Further violations are ignored. fault_clr=1 -> SYNC next edge, fault=0, code=0.
- fault_clr outside FAULT has no effect. If a violation and fault_clr occur in the same cycle in TRACK, the violation wins and enters FAULT.
- Counter saturates at all-ones and never wraps.
- With default parameters the nominal cycle is 8+3+6+3+4+3 = 27 cycles.

Decomposition:
- Package traffic_light_pkg:
  - lamp encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001
  - phase ids P1..P6 = 0..5
  - legal phase pattern table
  - fault code constants
  - monitor state enum SYNC/TRACK/FAULT
- One combinational sub-module, traffic_light_phase_decode: four lamp buses -> enc_ok, match, phase id.

Test Plan:
1. Reset controller and monitor together with default timing. Required: phase_valid=1 one cycle after reset release, phase=0, then 0,1,2,3,4,5 with dwells 8/3/6/3/4/3, cycle_done every 27 cycles, fault=0 for 5 full cycles.
2. Tracking P3, force light_S=3'b011 for one cycle. Required: next edge fault=1, fault_code=1, phase_valid=0, and it holds after the lights recover until fault_clr.
3. Drive M1=G, M2=G, MT=R, S=G. Required: fault_code=2.
4. P1 for 8 cycles, then P3 lights. Required: fault_code=3.
5. P1 for 8, P2 for 2, then P3. Required: fault_code=4. Separately, P1 for 8, P2 for 3, P3 held 7 cycles. Required: fault_code=5 on the 7th P3 sample.
6. In FAULT, assert fault_clr with P4 lights. Required: SYNC, then TRACK at phase=3 with no SHORT after a 1-cycle P4 followed by P5. Also rst asserted mid-P3: all outputs return to reset values at the next edge.
